fetch_pc_seq: RTL and testbench

- Program-counter sequencer for the RISC-V core.
- Consumes the 2-bit PCSrc produced by the branch decoder, plus PCTarget and ALUResult from execute.
- Owns the PC register and drives the instruction-memory fetch handshake, one outstanding request at a time.
- Holds each fetched instruction until the core retires it, then selects and fetches the next PC.

---
 rtl/fetch_pc_seq.sv | 152 +++++++++++++++
 tb/tb_fetch_pc_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_seq.sv
// -----------------------------------------------------------------------------
// fetch_pc_seq
//   Program-counter sequencer for the RISC-V core. It owns the PC register and
//   keeps at most one instruction-memory request in flight. It holds each
//   fetched word until the core retires it, then selects and fetches the next
//   PC.
//
//   Configuration macro:
//     FETCH_MISALIGN_TRAP_EN  when defined, a retire whose selected next PC has
//                             bit[1] set redirects to TRAP_VEC and pulses trap
//                             for one cycle. When undefined, the next PC is
//                             loaded unchanged and trap is constant 0.
//
//   Parameters:
//     RESET_PC    PC loaded on reset
//     TRAP_VEC    redirect address for a misaligned target (feature enabled)
//
//   Ports:
//     clk, reset_n            core clock, asynchronous active-low reset
//     PCSrc[1:0]              next-PC select (00 +4, 01 PCTarget, 1x jalr)
//     PCTarget[31:0]          PC+imm target (branches, jal)
//     ALUResult[31:0]         jalr target (bit 0 forced to 0)
//     pc_update               core retires the held instruction
//     imem_req / imem_addr    fetch request and address (imem_addr == PC)
//     imem_ack / imem_rdata   memory response; data sampled when ack=1
//     Instr / instr_valid     held instruction and its valid flag
//     PC / PCPlus4            current PC and PC+4 (combinational)
//     retire_cnt[31:0]        accepted pc_update events, wraps at 2^32
//     trap                    one-cycle misaligned-target pulse
// -----------------------------------------------------------------------------
module fetch_pc_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] PCTarget,
  input  logic [31:0] ALUResult,
  input  logic        pc_update,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic        instr_valid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [31:0] retire_cnt,
  output logic        trap
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] next_pc;
  logic [31:0] load_pc;
  logic        misalign;
  logic        do_retire;
  logic        do_capture;

  // ---------------------------------------------------------------------------
  // Next-PC selection. PCSrc[1] selects jalr regardless of PCSrc[0].
  // ---------------------------------------------------------------------------
  assign PCPlus4 = PC + 32'd4;

  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path can leave it unassigned and infer a latch.
    next_pc = PCPlus4;
    if (PCSrc[1])
      next_pc = ALUResult & ~32'h1;
    else if (PCSrc[0])
      next_pc = PCTarget;
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign = next_pc[1];
`else
  assign misalign = 1'b0;
`endif

  assign load_pc = misalign ? TRAP_VEC : next_pc;

  // ---------------------------------------------------------------------------
  // FSM: next state and outputs decoded from the current state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    do_retire   = 1'b0;
    do_capture  = 1'b0;
    unique case (state)
      BOOT: state_nxt = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          do_capture = 1'b1;
          state_nxt  = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (pc_update) begin
          do_retire = 1'b1;
          state_nxt = REQ;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  assign imem_addr = PC;

  // ---------------------------------------------------------------------------
  // State register. An asynchronous reset forces BOOT immediately, so imem_req
  // falls in the same cycle that reset_n goes low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!reset_n) state <= BOOT;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: Instr is a single architectural register and not a memory array,
    // so it is reset to a nop along with the rest of the state.
    if (!reset_n) begin
      PC         <= RESET_PC;
      Instr      <= NOP;
      retire_cnt <= '0;
      trap       <= 1'b0;
    end else begin
      trap <= do_retire & misalign;
      if (do_capture)
        Instr <= imem_rdata;
      if (do_retire) begin
        PC         <= load_pc;
        retire_cnt <= retire_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_seq.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_seq
//   Directed self-checking bench for fetch_pc_seq. Inputs change 1 ns after a
//   rising edge and outputs are checked there, away from the active edge.
//   Expectations for the misaligned-target step follow FETCH_MISALIGN_TRAP_EN.
// -----------------------------------------------------------------------------
module tb_fetch_pc_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  PCSrc;
  logic [31:0] PCTarget;
  logic [31:0] ALUResult;
  logic        pc_update;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Instr;
  logic        instr_valid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [31:0] retire_cnt;
  logic        trap;

  int tests = 0;
  int fails = 0;

  fetch_pc_seq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .PCSrc      (PCSrc),
    .PCTarget   (PCTarget),
    .ALUResult  (ALUResult),
    .pc_update  (pc_update),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .Instr      (Instr),
    .instr_valid(instr_valid),
    .PC         (PC),
    .PCPlus4    (PCPlus4),
    .retire_cnt (retire_cnt),
    .trap       (trap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From HOLD: retire with the given select, checking the new fetch address.
  task automatic retire(input logic [1:0] src, input logic [31:0] tgt,
                        input logic [31:0] alu, input logic [31:0] exp_addr,
                        input logic [31:0] exp_cnt, input string tag);
    PCSrc = src; PCTarget = tgt; ALUResult = alu; pc_update = 1'b1;
    tick();
    pc_update = 1'b0;
    check({tag, " req"},  {31'd0, imem_req}, 32'd1);
    check({tag, " addr"}, imem_addr, exp_addr);
    check({tag, " cnt"},  retire_cnt, exp_cnt);
  endtask

  // From REQ: acknowledge in the same cycle and land in HOLD.
  task automatic fetch(input logic [31:0] word);
    imem_ack = 1'b1; imem_rdata = word;
    tick();
    imem_ack = 1'b0;
    check("fetch valid", {31'd0, instr_valid}, 32'd1);
    check("fetch instr", Instr, word);
  endtask

  logic [31:0] exp_mis_addr;
  logic [31:0] exp_mis_trap;

  initial begin
`ifdef FETCH_MISALIGN_TRAP_EN
    exp_mis_addr = 32'h0000_0100;
    exp_mis_trap = 32'd1;
`else
    exp_mis_addr = 32'h0000_0022;
    exp_mis_trap = 32'd0;
`endif
    reset_n = 1'b0; PCSrc = 2'b00; PCTarget = '0; ALUResult = '0;
    pc_update = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    tick(); tick();

    // Reset state
    check("rst pc",    PC, 32'h0);
    check("rst req",   {31'd0, imem_req}, 32'd0);
    check("rst valid", {31'd0, instr_valid}, 32'd0);
    check("rst instr", Instr, 32'h0000_0013);
    check("rst cnt",   retire_cnt, 32'd0);
    check("rst trap",  {31'd0, trap}, 32'd0);

    // BOOT for one cycle, then REQ at RESET_PC; an ack in BOOT is ignored
    #2 reset_n = 1'b1;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    check("boot req", {31'd0, imem_req}, 32'd0);
    tick();
    imem_ack = 1'b0;
    check("req1 req",   {31'd0, imem_req}, 32'd1);
    check("req1 valid", {31'd0, instr_valid}, 32'd0);
    check("req1 addr",  imem_addr, 32'h0);
    check("req1 instr", Instr, 32'h0000_0013);

    // Ack in the same cycle as req: valid one cycle later
    fetch(32'h0050_0093);
    check("hold req", {31'd0, imem_req}, 32'd0);
    check("hold cnt", retire_cnt, 32'd0);

    // Sequential retires: 4, 8, 12, 16
    retire(2'b00, 32'h0, 32'h0, 32'h04, 32'd1, "seq1"); fetch(32'h1111_0001);
    retire(2'b00, 32'h0, 32'h0, 32'h08, 32'd2, "seq2"); fetch(32'h1111_0002);
    retire(2'b00, 32'h0, 32'h0, 32'h0C, 32'd3, "seq3"); fetch(32'h1111_0003);
    retire(2'b00, 32'h0, 32'h0, 32'h10, 32'd4, "seq4"); fetch(32'h1111_0004);
    check("pcplus4 at 0x10", PCPlus4, 32'h14);

    // Branch target, then jalr via PCSrc=11 (bit 0 cleared)
    retire(2'b01, 32'h40, 32'h0, 32'h40, 32'd5, "br");   fetch(32'h2222_0001);
    retire(2'b11, 32'h44, 32'h81, 32'h80, 32'd6, "jalr11");

    // Delayed ack: req held 4 cycles, pc_update in REQ ignored
    pc_update = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wait req",  {31'd0, imem_req}, 32'd1);
      check("wait addr", imem_addr, 32'h80);
      check("wait cnt",  retire_cnt, 32'd6);
    end
    pc_update = 1'b0;
    fetch(32'h3333_0001);

    // Ack in HOLD is ignored, instruction stays put
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    tick();
    imem_ack = 1'b0;
    check("hold ack instr", Instr, 32'h3333_0001);
    check("hold ack valid", {31'd0, instr_valid}, 32'd1);

    // Misaligned target
    retire(2'b01, 32'h22, 32'h0, exp_mis_addr, 32'd7, "mis");
    check("mis trap", {31'd0, trap}, exp_mis_trap);
    tick();
    check("mis trap clr", {31'd0, trap}, 32'd0);
    fetch(32'h4444_0001);

    // PC wrap at 2^32
    retire(2'b01, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC, 32'd8, "tgt top");
    check("pcplus4 wrap", PCPlus4, 32'h0);
    fetch(32'h5555_0001);
    retire(2'b00, 32'h0, 32'h0, 32'h0, 32'd9, "wrap");
    fetch(32'h5555_0002);

    // PCSrc=10 selects jalr over PCTarget
    retire(2'b10, 32'h999, 32'h40, 32'h40, 32'd10, "jalr10");

    // Reset while in REQ at 0x40: request drops immediately
    #2 reset_n = 1'b0;
    #1;
    check("mid rst req",   {31'd0, imem_req}, 32'd0);
    check("mid rst pc",    PC, 32'h0);
    check("mid rst cnt",   retire_cnt, 32'd0);
    check("mid rst instr", Instr, 32'h0000_0013);
    tick();
    #2 reset_n = 1'b1;
    check("rel boot req", {31'd0, imem_req}, 32'd0);
    tick();
    check("rel req",  {31'd0, imem_req}, 32'd1);
    check("rel addr", imem_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog: the directed sequence is short; anything longer is a hang.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
